// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one external combinational Booth
// multiplier among NREQ requesters, with one operation in flight at a time.
module booth_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_p,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_p,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    // Handshakes: a transfer on index i happens at a rising edge where valid[i] and
    // ready[i] are both high. rsp_valid, once raised, holds with rsp_p/rsp_id until
    // that edge; a requester may withdraw req_valid at any time before its grant.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    // Grant is a pure function of state, rr_ptr and req_valid; data inputs never
    // influence ready, so requesters can build valid without a combinational loop.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        if (state == IDLE) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_found && req_valid[wrap_add(rr_ptr, i)]) begin
                    grant_found = 1'b1;
                    grant_idx   = wrap_add(rr_ptr, i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mul_a  <= req_a[grant_idx*WIDTH +: WIDTH];
                        mul_b  <= req_b[grant_idx*WIDTH +: WIDTH];
                        rsp_id <= grant_idx;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // mul_p has had a full cycle to settle from the operand registers.
                    rsp_p     <= mul_p;
                    rsp_valid <= NREQ'(1) << rsp_id;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[rsp_id]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= wrap_add(rsp_id, 1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
